// File: rtl/decode.sv
// Instruction-decode stage: splits the fetched word into fields, reads the
// register file (with same-edge write-back bypass) and registers the ID_EX bundle.
module decode (
  input  logic         clock,
  input  logic         reset,
  input  logic [63:0]  IF_ID,
  input  logic [70:0]  EX_WB,
  output logic [145:0] ID_EX,
  output logic         raw_hazard,
  output logic [31:0]  decoded_count
);

  logic [31:0] rf [32];
  logic        if_valid;

  logic [31:0] instr, pc;
  logic [5:0]  opcode, funct_d;
  logic [4:0]  rs, rt, rd, dest;
  logic        is_r;
  logic [31:0] imm_ext, rs_val, rt_val;

  logic        squash, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        new_valid, prev_valid, hazard_n;
  logic [4:0]  prev_dest;

  // Redirect target and shamt are not consumed by this stage.
  logic unused_ok;
  assign unused_ok = ^{EX_WB[63:32], IF_ID[10:6]};

  assign instr   = IF_ID[31:0];
  assign pc      = IF_ID[63:32];
  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign is_r    = (opcode == 6'd0);
  assign dest    = is_r ? rd : rt;
  assign funct_d = is_r ? instr[5:0] : 6'd0;
  assign imm_ext = {{16{instr[15]}}, instr[15:0]};

  assign squash  = EX_WB[70];
  assign wb_addr = EX_WB[68:64];
  assign wb_data = EX_WB[31:0];
  assign wb_en   = EX_WB[69] && (wb_addr != 5'd0);

  // A write landing on the same edge must be visible to the instruction read now.
  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (wb_en && wb_addr == rs) rs_val = wb_data;
    if (wb_en && wb_addr == rt) rt_val = wb_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  assign new_valid  = if_valid && !squash;
  assign prev_valid = ID_EX[145];
  assign prev_dest  = ID_EX[132:128];

  // rt is only a source operand for R-type; for I-type it is the destination.
  always_comb begin
    hazard_n = 1'b0;
    if (new_valid && prev_valid && prev_dest != 5'd0)
      hazard_n = (prev_dest == rs) || (is_r && prev_dest == rt);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if_valid      <= 1'b0;
      ID_EX         <= '0;
      raw_hazard    <= 1'b0;
      decoded_count <= '0;
    end else begin
      if_valid      <= 1'b1;
      ID_EX         <= {new_valid, opcode, funct_d, dest, pc, rs_val, rt_val, imm_ext};
      raw_hazard    <= hazard_n;
      if (new_valid) decoded_count <= decoded_count + 32'd1;
    end
  end

endmodule
